pattern_selector: RTL and testbench
===================================

# pattern_selector

Upstream control stage for the 8x8 dot-matrix display driver. Turns two raw push-buttons and an auto-mode switch into the 4-bit `pattern_id` that selects one of the 15 stored seed patterns. The block synchronises and debounces the buttons, detects presses, optionally auto-advances on a timer, and wraps the selection within 1..15. `pattern_id` = 0 (blank) is never produced.

## Interface
Parameters:
- `DB_LEN`, default 50000: consecutive cycles a synchronised button level must differ from its debounced state before that state is accepted; legal range 2..2^26-1.
- `AUTO_LEN`, default 25000000: auto-advance period in cycles; legal range 2..2^26-1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-low.
- `btn_next`  in  1  raw button, active-high, asynchronous and bouncing.
- `btn_prev`  in  1  raw button, active-high, asynchronous and bouncing.
- `sw_auto`  in  1  raw level switch; 1 enables auto-advance.
- `pattern_id`  out  4  registered current pattern selection, range 1..15.
- `pattern_change`  out  1  registered one-cycle pulse, coincident with every update of `pattern_id`.

## Operation
- **Synchronisers.** `btn_next`, `btn_prev` and `sw_auto` each pass through a 2-flop synchroniser (s1, then s2).
- **Debouncer, one per button.**
  - Holds a `stable` bit and a 26-bit `cnt`.
  - On each edge where s2 != `stable`: if `cnt` == DB_LEN-1, then `stable` <= s2 and `cnt` <= 0; otherwise `cnt` <= `cnt`+1.
  - On any edge where s2 == `stable`: `cnt` <= 0.
- **Press detect.** `press` = `stable` & ~`stable_d`, where `stable_d` is `stable` delayed by one cycle. One pulse per accepted press. Releases generate nothing.
- **Auto timer.** 26-bit `acnt`.
  - While the synchronised `sw_auto` = 0: `acnt` is held at 0 and no tick is generated.
  - While it is 1: `acnt` increments. When `acnt` == AUTO_LEN-1, it wraps to 0 and a `tick` pulse is generated that cycle.
- **Step rule** (evaluated each cycle, priority top-down):
  1. `next_press` & `prev_press`: no change; `tick` is discarded; `acnt` <= 0.
  2. `next_press` only: `pattern_id` increments, 15 wraps to 1; `tick` is discarded; `acnt` <= 0.
  3. `prev_press` only: `pattern_id` decrements, 1 wraps to 15; `tick` is discarded; `acnt` <= 0.
  4. `tick` only: increment as in rule 2.
  5. Otherwise: hold.
- `pattern_change` <= 1 exactly on the edges where rule 2, 3 or 4 fires; 0 otherwise.
- **Reset** (rst = 0 at a clock edge; applies mid-operation as well):
  - `pattern_id` = 4'd1, `pattern_change` = 0.
  - All synchroniser flops, `stable`, `stable_d`, `cnt` and `acnt` = 0.
  - Any press or tick in progress is lost.

## Timing
- Press latency: first edge sampling raw `btn_next` = 1 is edge 1.
  - s2 = 1 after edge 2.
  - `stable` = 1 after edge DB_LEN+2.
  - `pattern_id` updates and `pattern_change` = 1 after edge DB_LEN+3.
  - `pattern_change` falls after edge DB_LEN+4.
- Glitch rejection: a raw pulse shorter than DB_LEN cycles, as seen at s2, produces no press; `cnt` restarts on every bounce.
- Auto period: with `sw_auto` steady high, successive ticks are exactly AUTO_LEN cycles apart. The first tick occurs AUTO_LEN cycles after s2 of `sw_auto` first reads 1.
- A manual press restarts the auto period: the next tick comes AUTO_LEN cycles after the press cycle.
- At most one step per cycle; `pattern_id` never leaves 1..15.

## Test plan
(DB_LEN=4, AUTO_LEN=10 unless noted.)
1. **Reset.** Hold rst=0 for 3 cycles with all inputs toggling -> `pattern_id`=1, `pattern_change`=0; no change for 20 cycles after release with inputs low.
2. **Next with wrap.** Press `btn_next` cleanly 15 times, each held 8 cycles with 8-cycle gaps -> ids 2,3,…,15,1. Each update occurs at edge 7 after the raw rise, with exactly one `pattern_change` pulse per press.
3. **Prev wrap and bounce.**
   - From id=1, apply `btn_prev` bouncing 1,0,1,1,0 then steady high -> single decrement to 15 after the steady run.
   - A 3-cycle glitch alone -> no change.
4. **Auto mode.** `sw_auto`=1 from id=14 -> 15, then 1, then 2 at 10-cycle spacing; `sw_auto`=0 -> id frozen, `acnt` held at 0.
5. **Simultaneous events.**
   - Both buttons press on the same cycle -> id unchanged, no pulse.
   - `next_press` coinciding with `tick` -> single increment; next tick 10 cycles later.
6. **Reset mid-operation.** Assert rst while `btn_next` is held at debounce count 2 and auto is mid-period -> id=1; after rst deasserts with the button still held, the press is accepted only after a full DB_LEN+2 cycles.

Source files
------------

// File: rtl/pattern_selector.sv
// Debounced next/prev buttons plus auto-advance timer select a display pattern in 1..15.
// Raw press to pattern_id update takes DB_LEN+3 cycles; outputs are free-running with no backpressure.
module pattern_selector #(
    parameter int unsigned DB_LEN   = 50000,
    parameter int unsigned AUTO_LEN = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       sw_auto,
    output logic [3:0] pattern_id,
    output logic       pattern_change
);

    localparam logic [25:0] DB_LAST   = 26'(DB_LEN - 1);
    localparam logic [25:0] AUTO_LAST = 26'(AUTO_LEN - 1);

    // Bit 0 = next, bit 1 = prev, bit 2 = auto switch.
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [1:0]  stable;
    logic [1:0]  stable_d;
    logic [1:0]  press;
    logic [25:0] cnt [2];
    logic [25:0] acnt;
    logic        tick;
    logic        step_up;
    logic        step_dn;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sw_auto, btn_prev, btn_next};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stable   <= '0;
            stable_d <= '0;
            for (int b = 0; b < 2; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != stable[b]) begin
                    if (cnt[b] == DB_LAST) begin
                        stable[b] <= sync2[b];
                        cnt[b]    <= '0;
                    end else begin
                        cnt[b] <= cnt[b] + 26'd1;
                    end
                end else begin
                    cnt[b] <= '0;
                end
            end
        end
    end

    assign press = stable & ~stable_d;
    assign tick  = sync2[2] && (acnt == AUTO_LAST);

    // Simultaneous presses cancel; any manual press swallows a coincident tick.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        case (press)
            2'b01:   step_up = 1'b1;
            2'b10:   step_dn = 1'b1;
            2'b00:   step_up = tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acnt <= '0;
        end else if (!sync2[2] || (|press) || tick) begin
            acnt <= '0;
        end else begin
            acnt <= acnt + 26'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_id     <= 4'd1;
            pattern_change <= 1'b0;
        end else begin
            pattern_change <= step_up | step_dn;
            if (step_up) begin
                pattern_id <= (pattern_id == 4'd15) ? 4'd1 : pattern_id + 4'd1;
            end else if (step_dn) begin
                pattern_id <= (pattern_id == 4'd1) ? 4'd15 : pattern_id - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_selector.sv
// Randomised and directed stimulus for pattern_selector, checked by a scoreboard fed from a
// behavioural model of the selection rules.
module tb_pattern_selector;

    localparam int DB_LEN   = 4;
    localparam int AUTO_LEN = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       sw_auto = 1'b0;
    logic [3:0] pattern_id;
    logic       pattern_change;

    always #5 clk = ~clk;

    pattern_selector #(.DB_LEN(DB_LEN), .AUTO_LEN(AUTO_LEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .sw_auto        (sw_auto),
        .pattern_id     (pattern_id),
        .pattern_change (pattern_change)
    );

    typedef struct {
        int edge_no;
        int id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;

    // Model state: raw-input delay line, per-button accepted level and run length of
    // disagreement, a "rose on the last edge" flag, and cycles since the auto period began.
    int m_id = 1;
    bit m_s1 [3];
    bit m_s2 [3];
    bit m_level [2];
    bit m_rose [2];
    int m_run [2];
    int m_age = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, edge_n);
        end
    endtask

    function automatic void model_edge(bit r, bit n, bit p, bit a);
        bit   np, pp, tk;
        int   nid;
        exp_t e;
        if (!r) begin
            m_id = 1;
            m_age = 0;
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0;
                m_s2[i] = 0;
            end
            for (int b = 0; b < 2; b++) begin
                m_level[b] = 0;
                m_rose[b]  = 0;
                m_run[b]   = 0;
            end
            return;
        end
        np  = m_rose[0];
        pp  = m_rose[1];
        tk  = m_s2[2] && (m_age == AUTO_LEN - 1);
        nid = m_id;
        if (np && pp) nid = m_id;
        else if (np || (!pp && tk)) nid = (m_id % 15) + 1;
        else if (pp) nid = (m_id == 1) ? 15 : m_id - 1;
        if (nid != m_id) begin
            e.edge_no = edge_n + 1;
            e.id      = nid;
            sb.push_back(e);
            m_id = nid;
        end
        if (!m_s2[2] || np || pp || tk) m_age = 0;
        else m_age++;
        for (int b = 0; b < 2; b++) begin
            m_rose[b] = 0;
            if (m_s2[b] != m_level[b]) begin
                m_run[b]++;
                if (m_run[b] == DB_LEN) begin
                    m_level[b] = m_s2[b];
                    m_run[b]   = 0;
                    m_rose[b]  = m_level[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1[0] = n;
        m_s1[1] = p;
        m_s1[2] = a;
    endfunction

    task automatic cyc(input bit r, input bit n, input bit p, input bit a);
        rst      = r;
        btn_next = n;
        btn_prev = p;
        sw_auto  = a;
        model_edge(r, n, p, a);
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1, 0, 0, 0);
    endtask

    // Monitor: every pattern_change pulse must match the oldest expected update in id and edge.
    always @(negedge clk) begin
        if (edge_n > 0) begin
            checks++;
            if (pattern_id < 4'd1 || pattern_id > 4'd15) begin
                failures++;
                $display("FAIL id_range: got %0d expected 1..15 (edge %0d)", pattern_id, edge_n);
            end
            while (sb.size() > 0 && sb[0].edge_no < edge_n) begin
                checks++;
                failures++;
                $display("FAIL missed_change: no pulse at edge %0d, expected id %0d",
                         sb[0].edge_no, sb[0].id);
                void'(sb.pop_front());
            end
            if (pattern_change) begin
                if (sb.size() > 0 && sb[0].edge_no == edge_n) begin
                    check("change_id", int'(pattern_id), sb[0].id);
                    void'(sb.pop_front());
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_change: pulse at edge %0d with id %0d, none expected",
                             edge_n, pattern_id);
                end
            end
        end
    end

    initial begin
        bit rn, rp, ra, rr;
        int hn, hp, ha;

        // Reset with toggling inputs, then quiet.
        for (int i = 0; i < 3; i++) cyc(0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                                        1'($urandom_range(1, 0)));
        check("reset_id", int'(pattern_id), 1);
        check("reset_change", int'(pattern_change), 0);
        idle(20);
        check("quiet_id", int'(pattern_id), 1);

        // Fifteen clean next presses, wrapping 15 -> 1.
        for (int i = 1; i <= 15; i++) begin
            for (int k = 0; k < 8; k++) cyc(1, 1, 0, 0);
            idle(8);
            check("next_press_id", int'(pattern_id), (i % 15) + 1);
        end

        // Bouncing prev press: one decrement 1 -> 15.
        cyc(1, 0, 1, 0); cyc(1, 0, 0, 0); cyc(1, 0, 1, 0); cyc(1, 0, 1, 0); cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) cyc(1, 0, 1, 0);
        idle(8);
        check("prev_bounce_id", int'(pattern_id), 15);
        for (int k = 0; k < 3; k++) cyc(1, 0, 1, 0);
        idle(10);
        check("glitch_id", int'(pattern_id), 15);

        // Down to 14, then auto-advance 15, 1, 2; switch off freezes.
        for (int k = 0; k < 8; k++) cyc(1, 0, 1, 0);
        idle(8);
        check("prev_to_14", int'(pattern_id), 14);
        for (int k = 0; k < 33; k++) cyc(1, 0, 0, 1);
        check("auto_id", int'(pattern_id), 2);
        idle(30);
        check("auto_frozen_id", int'(pattern_id), 2);

        // Both buttons together cancel.
        for (int k = 0; k < 8; k++) cyc(1, 1, 1, 0);
        idle(8);
        check("both_press_id", int'(pattern_id), 2);

        // Next press landing on the same edge as a tick gives one increment.
        for (int k = 1; k <= 58; k++) cyc(1, (k >= 16 && k < 24), 0, 1);
        idle(10);
        check("press_tick_id", int'(pattern_id), 7);

        // Reset mid-debounce and mid-period, button still held afterwards.
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 1);
        check("midrst_id", int'(pattern_id), 1);
        check("midrst_change", int'(pattern_change), 0);
        for (int k = 0; k < 10; k++) cyc(1, 1, 0, 1);
        check("post_rst_press_id", int'(pattern_id), 2);
        idle(12);

        // Randomised button levels, auto switch and occasional reset.
        hn = 0; hp = 0; ha = 0;
        rn = 0; rp = 0; ra = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hn == 0) begin rn = 1'($urandom_range(1, 0)); hn = $urandom_range(12, 1); end
            if (hp == 0) begin rp = 1'($urandom_range(1, 0)); hp = $urandom_range(12, 1); end
            if (ha == 0) begin ra = 1'($urandom_range(1, 0)); ha = $urandom_range(80, 20); end
            hn--; hp--; ha--;
            rr = ($urandom_range(599, 0) != 0);
            cyc(rr, rn, rp, ra);
        end
        idle(DB_LEN + 6);
        check("final_id", int'(pattern_id), m_id);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
